// File: rtl/phase_a_stream_pkg.sv
// Shared FSM encoding and sizing helpers for the limb-serial Barrett-style reduction step.
package phase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAMMA,
    ST_SUB,
    ST_CORR,
    ST_DONE
  } state_t;

  localparam int GAMMA_LAT = 2;

  function automatic int calc_nl(input int size, input int limb);
    return (size + 2 + limb - 1) / limb;
  endfunction

endpackage

// File: rtl/phase_a_stream_limb_msub.sv
// One limb of a - gamma*m: LIMB-bit difference plus a signed carry in [-2^GW, 0] for the next limb.
module limb_msub #(
  parameter int RADIX    = 72,
  parameter int SIZE_LOG = 6,
  parameter int LIMB     = 128
) (
  input  logic                           [LIMB-1:0] a_i,
  input  logic             [RADIX+SIZE_LOG-1:0]     gamma,
  input  logic                           [LIMB-1:0] m_i,
  input  logic signed      [RADIX+SIZE_LOG:0]       carry_in,
  output logic                           [LIMB-1:0] diff,
  output logic signed      [RADIX+SIZE_LOG:0]       carry_out
);

  localparam int GW = RADIX + SIZE_LOG;
  localparam int FW = LIMB + GW + 2;

  logic        [GW+LIMB-1:0] prod;
  logic signed [FW-1:0]      full;

  always_comb begin
    prod      = {{LIMB{1'b0}}, gamma} * {{GW{1'b0}}, m_i};
    full      = $signed({{(GW+2){1'b0}}, a_i})
              - $signed({2'b00, prod})
              + $signed({{(LIMB+1){carry_in[GW]}}, carry_in});
    diff      = full[LIMB-1:0];
    carry_out = full[LIMB+GW:LIMB];
  end

endmodule

// File: rtl/phase_a_stream.sv
// Single-step modular reduction: estimate gamma from the top digit, subtract gamma*m limb by limb,
// then apply one conditional subtraction of m.
module phase_a_stream
  import phase_pkg::*;
#(
  parameter int SIZE     = 3072,
  parameter int RADIX    = 72,
  parameter int SIZE_LOG = 6,
  parameter int LIMB     = 128
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [SIZE+RADIX+SIZE_LOG-1:0]     a,
  input  logic [SIZE-1:0]                    m,
  input  logic [RADIX+SIZE_LOG+1:0]          m_prime,
  input  logic                               if_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SIZE-1:0]                    new_a,
  output logic                               busy
);

  localparam int AW   = SIZE + RADIX + SIZE_LOG;
  localparam int GW   = RADIX + SIZE_LOG;
  localparam int PW   = GW + 2;
  localparam int NL   = calc_nl(SIZE, LIMB);
  localparam int LW   = NL * LIMB;
  localparam int CW   = $clog2(NL) + 1;
  localparam int TOPB = SIZE + 2 - (NL - 1) * LIMB;
  localparam logic [LIMB-1:0] TOP_MASK = {LIMB{1'b1}} >> (LIMB - TOPB);

  function automatic logic [GW-1:0] sel_digit(input logic [AW-1:0] av, input logic last);
    if (last) return av[AW-1 -: GW];
    return GW'(av[SIZE+RADIX-1 -: RADIX]);
  endfunction

  function automatic logic [PW-1:0] sel_const(input logic [PW-1:0] mp, input logic last);
    return last ? mp : (mp >> SIZE_LOG);
  endfunction

  function automatic logic [GW-1:0] quot_est(input logic [GW+PW-1:0] prod);
    return GW'(prod >> GW);
  endfunction

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    out_valid_r;
  logic [LW-1:0]           a_r;
  logic [LW-1:0]           s_r;
  logic [GW-1:0]           t_p0;
  logic [PW-1:0]           p_p0;
  logic [GW+PW-1:0]        prod_p1;
  logic [GW-1:0]           gamma_p2;
  logic signed [GW:0]      carry_r;
  logic                    borrow_r;

  logic [LW-1:0]           m_pad;
  logic [LIMB-1:0]         m_limb;
  logic [LIMB-1:0]         sub_diff;
  logic signed [GW:0]      sub_carry;
  logic [LIMB:0]           corr_full;
  logic                    last_limb;
  logic                    accept;

  assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  assign out_valid = out_valid_r;
  assign new_a     = out_valid_r ? a_r[SIZE-1:0] : '0;
  assign last_limb = (cnt == CW'(NL - 1));
  assign m_pad     = LW'(m);
  assign m_limb    = LIMB'(m_pad >> (LIMB * int'(cnt)));
  assign corr_full = {1'b0, a_r[LIMB-1:0]} - {1'b0, m_limb} - {{LIMB{1'b0}}, borrow_r};

  limb_msub #(
    .RADIX   (RADIX),
    .SIZE_LOG(SIZE_LOG),
    .LIMB    (LIMB)
  ) u_msub (
    .a_i      (a_r[LIMB-1:0]),
    .gamma    (gamma_p2),
    .m_i      (m_limb),
    .carry_in (carry_r),
    .diff     (sub_diff),
    .carry_out(sub_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      a_r         <= '0;
      s_r         <= '0;
      t_p0        <= '0;
      p_p0        <= '0;
      prod_p1     <= '0;
      gamma_p2    <= '0;
      carry_r     <= '0;
      borrow_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        // p0 -> p1 -> p2: digit*constant product, then shift down to the quotient estimate
        ST_GAMMA: begin
          prod_p1  <= {{PW{1'b0}}, t_p0} * {{GW{1'b0}}, p_p0};
          gamma_p2 <= quot_est(prod_p1);
          if (cnt == CW'(GAMMA_LAT - 1)) begin
            state   <= ST_SUB;
            cnt     <= '0;
            carry_r <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // r = a - gamma*m, rotated in LSB limb first; top limb trimmed to SIZE+2 bits
        ST_SUB: begin
          a_r     <= {(last_limb ? (sub_diff & TOP_MASK) : sub_diff), a_r[LW-1:LIMB]};
          carry_r <= sub_carry;
          if (last_limb) begin
            state    <= ST_CORR;
            cnt      <= '0;
            borrow_r <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // r and r-m rotate together; the final borrow picks the survivor
        ST_CORR: begin
          borrow_r <= corr_full[LIMB];
          if (last_limb) begin
            a_r         <= corr_full[LIMB] ? {a_r[LIMB-1:0], a_r[LW-1:LIMB]}
                                           : {corr_full[LIMB-1:0], s_r[LW-1:LIMB]};
            state       <= ST_DONE;
            cnt         <= '0;
            out_valid_r <= 1'b1;
          end else begin
            a_r <= {a_r[LIMB-1:0], a_r[LW-1:LIMB]};
            s_r <= {corr_full[LIMB-1:0], s_r[LW-1:LIMB]};
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        a_r         <= LW'(a);
        t_p0        <= sel_digit(a, if_last);
        p_p0        <= sel_const(m_prime, if_last);
        state       <= ST_GAMMA;
        cnt         <= '0;
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phase_a_stream.sv
// Directed and randomized checks of phase_a_stream against a whole-number arithmetic reference.
module tb_phase_a_stream;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [273:0] a_in;
  logic [255:0] m_in;
  logic [19:0]  mp_in;
  logic         last_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] new_a;
  logic         busy;

  int vectors;
  int miscompares;

  phase_a_stream #(
    .SIZE    (256),
    .RADIX   (16),
    .SIZE_LOG(2),
    .LIMB    (64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a_in),
    .m        (m_in),
    .m_prime  (mp_in),
    .if_last  (last_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .new_a    (new_a),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] rnd320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: gamma from the top digit, then (a - gamma*m) mod 2^258 and one conditional subtract.
  function automatic logic [255:0] ref_out(input logic [273:0] av, input logic [19:0] mp,
                                           input logic last, input logic [255:0] mv);
    logic [639:0] t, p, g, r, mw;
    t = 640'(av >> 256);
    if (!last) t = t & 640'hFFFF;
    p  = last ? 640'(mp) : 640'(mp >> 2);
    g  = ((t * p) >> 18) & ((640'd1 << 18) - 640'd1);
    mw = 640'(mv);
    r  = (640'(av) - g * mw) & ((640'd1 << 258) - 640'd1);
    if (r >= mw) r = r - mw;
    return r[255:0];
  endfunction

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_op(input logic [273:0] av, input logic [19:0] mp, input logic last,
                        input logic [255:0] expv, input string tag);
    int cyc;
    a_in     = av;
    mp_in    = mp;
    last_in  = last;
    in_valid = 1'b1;
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk1({tag, "_busy"}, busy, 1'b1);
    wait_valid(cyc);
    chk_int({tag, "_latency"}, cyc, 12);
    chk({tag, "_new_a"}, new_a, expv);
    step();
    chk1({tag, "_out_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_new_a_zero"}, new_a, 256'd0);
  endtask

  initial begin
    logic [255:0] mm;
    logic [273:0] av, bv;
    logic [319:0] r320;
    logic [639:0] t, g0, pw;
    logic [19:0]  mpa, mpb;
    logic [255:0] expa, expb;
    logic         la, lb;
    int           cyc, hits, k;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a_in        = '0;
    mp_in       = '0;
    last_in     = 1'b0;
    mm          = (256'd1 << 255) - 256'd19;
    m_in        = mm;

    step();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid2", out_valid, 1'b0);
    chk1("rst_busy2", busy, 1'b0);
    chk("rst_new_a", new_a, 256'd0);

    // Directed boundaries: gamma is zero because the top digit of a is zero.
    run_op(274'(mm), 20'(($urandom)), 1'b0, 256'd0, "a_eq_m");
    av = (274'(mm) << 1) - 274'd1;
    run_op(av, 20'(($urandom)), 1'b0, mm - 256'd1, "a_2m_minus1");
    run_op(274'(mm) - 274'd1, 20'(($urandom)), 1'b0, mm - 256'd1, "a_m_minus1");

    // Final-step alignment: a = g0*m + 5 with m_prime chosen so the estimate lands on g0.
    k  = int'($urandom_range(1, 1000));
    g0 = 640'(2 * k + 1);
    av = 274'(g0 * 640'(mm) + 640'd5);
    t  = 640'(av >> 256);
    pw = ((g0 << 18) + t - 640'd1) / t;
    run_op(av, pw[19:0], 1'b1, 256'd5, "last_gamma0");

    // Randomized operands and moduli, including violations of the range guarantee.
    for (int i = 0; i < 8; i++) begin
      r320 = rnd320();
      m_in = r320[255:0] | 256'd1;
      r320 = rnd320();
      av   = r320[273:0];
      mpa  = 20'($urandom);
      la   = 1'($urandom);
      run_op(av, mpa, la, ref_out(av, mpa, la, m_in), "rand");
    end
    m_in = mm;

    // Output stall with a competing request held on the input.
    r320 = rnd320(); av = r320[273:0]; mpa = 20'($urandom); la = 1'($urandom);
    r320 = rnd320(); bv = r320[273:0]; mpb = 20'($urandom); lb = 1'($urandom);
    expa = ref_out(av, mpa, la, mm);
    expb = ref_out(bv, mpb, lb, mm);
    out_ready = 1'b0;
    a_in = av; mp_in = mpa; last_in = la; in_valid = 1'b1;
    step();
    a_in = bv; mp_in = mpb; last_in = lb;
    wait_valid(cyc);
    chk_int("stall_latency", cyc, 12);
    for (int i = 0; i < 5; i++) begin
      chk1("stall_out_valid", out_valid, 1'b1);
      chk("stall_new_a", new_a, expa);
      chk1("stall_in_ready", in_ready, 1'b0);
      step();
    end
    chk("stall_new_a_end", new_a, expa);
    out_ready = 1'b1;
    #1;
    chk1("release_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk1("release_accept_busy", busy, 1'b1);
    chk1("release_out_valid", out_valid, 1'b0);
    wait_valid(cyc);
    chk_int("release_latency", cyc, 12);
    chk("release_new_a", new_a, expb);
    step();

    // Back-to-back: second request waits on the input and is taken on the output handshake.
    r320 = rnd320(); av = r320[273:0]; mpa = 20'($urandom); la = 1'($urandom);
    r320 = rnd320(); bv = r320[273:0]; mpb = 20'($urandom); lb = 1'($urandom);
    expa = ref_out(av, mpa, la, mm);
    expb = ref_out(bv, mpb, lb, mm);
    a_in = av; mp_in = mpa; last_in = la; in_valid = 1'b1;
    step();
    a_in = bv; mp_in = mpb; last_in = lb;
    wait_valid(cyc);
    chk_int("b2b_first_latency", cyc, 12);
    chk("b2b_first_new_a", new_a, expa);
    chk1("b2b_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk1("b2b_second_busy", busy, 1'b1);
    wait_valid(cyc);
    chk_int("b2b_second_latency", cyc, 12);
    chk("b2b_second_new_a", new_a, expb);
    step();

    // Reset in the middle of the subtraction pass.
    r320 = rnd320(); av = r320[273:0]; mpa = 20'($urandom);
    a_in = av; mp_in = mpa; last_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_new_a", new_a, 256'd0);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid === 1'b1) hits++;
    end
    chk_int("midrst_no_stale", hits, 0);
    r320 = rnd320(); av = r320[273:0]; mpa = 20'($urandom); la = 1'($urandom);
    run_op(av, mpa, la, ref_out(av, mpa, la, mm), "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
